unsigned_divider_seq: RTL and testbench
=======================================

Name: unsigned_divider_seq

Overview:
- Parametrised, multi-cycle restoring divider. It is the successor to the team's single-cycle 4-bit divider.
- Computes one quotient bit per clock, so it closes timing at larger widths.
- Uses a start/busy/done handshake.
- Reports divide-by-zero as a sideband flag, not a magic output code.
- Sits behind the tile I/O wrapper. The wrapper drives the operands and samples the results.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal values are 2 to 32.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. This is derived and must not be overridden.

Ports:
- clk  input  1  the only clock. Rising edge active.
- rst_n  input  1  asynchronous, active-low reset. Asserts asynchronously; deasserted by the system synchronously to clk.
- ena  input  1  global enable. When 0, all state freezes.
- start  input  1  request to begin a division. Sampled only when accepted (see Behaviour).
- dividend  input  WIDTH  numerator. Captured on the accept edge.
- divisor  input  WIDTH  denominator. Captured on the accept edge.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse: results are valid.
- quotient  output  WIDTH  result quotient. Held until the next accept.
- remainder  output  WIDTH  result remainder. Held until the next accept.
- div_by_zero  output  1  the last accepted operation had divisor==0. Held until the next accept.

Behaviour:
- Reset values: FSM=IDLE; busy, done, div_by_zero, quotient, remainder, counter and internal registers are all 0. Reset asserted mid-operation aborts immediately; no done is produced.
- FSM states are IDLE, RUN and DONE.
- ena=0 holds every register, including the FSM, counter and outputs. start is ignored. done stays at its current value, so done-high cycles lengthen accordingly. Latency is counted in ena=1 cycles only.
- Accept condition: ena=1 && start=1 && state in {IDLE, DONE}. Back-to-back operations are allowed from DONE.
- start while in RUN is ignored and has no side effects.
- Accept edge, divisor!=0:
  - Capture the operands.
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - Clear div_by_zero.
  - Go to RUN. busy=1 from the next cycle.
- Each RUN edge performs one iteration:
  - Shift {rem, q} left by 1, bringing in the dividend MSB.
  - If rem >= divisor: rem -= divisor and the q LSB = 1; else the q LSB = 0.
  - counter++.
- After the WIDTH-th iteration edge:
  - quotient and remainder registers update.
  - Go to DONE: busy=0, done=1 for exactly one ena=1 cycle, then IDLE.
  - Latency: done is high in the cycle after the (WIDTH+1)-th ena=1 edge counting the accept edge. For WIDTH=8 that is 9 edges.
- Accept edge, divisor==0:
  - Skip RUN and go directly to DONE; done=1 in the cycle after the accept edge. busy never rises.
  - quotient = all ones, remainder = dividend, div_by_zero=1.
- Outputs change only on entry to DONE. Between operations they hold their last values; they are not cleared on return to IDLE.
- dividend < divisor gives quotient=0 and remainder=dividend via the normal WIDTH-cycle path; there is no early exit.
- Arithmetic is unsigned and modulo-free. The partial remainder is WIDTH+1 bits internally so the compare never overflows. Results are exact for all operand pairs.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), sampled on the accept edge.
  - signed_mode=1 treats operands as two's complement.
  - Magnitudes are taken at accept and divided with the unsigned core. Signs are fixed on the final iteration edge, so latency is unchanged.
  - The quotient truncates toward zero; the remainder takes the dividend's sign.
  - Overflow case MIN/-1 gives quotient=MIN and remainder=0.
  - Divide by zero gives quotient=all ones, remainder=dividend, div_by_zero=1.
- Undefined: the port does not exist and the behaviour is purely unsigned.

Test Plan:
- WIDTH=8, 200/7 with start pulse → busy for 8 cycles; done one cycle after the 9th edge; quotient=28, remainder=4, div_by_zero=0. 255/1 → 255, 0.
- 5/0 → done in the cycle after accept, busy never high; quotient=0xFF, remainder=5, div_by_zero=1. Next op 9/3 → div_by_zero clears; result 3, 0.
- 3/10 → quotient=0, remainder=3 after full latency. start re-asserted with 100/9 during RUN → ignored; first result 0/3 unaffected.
- Back-to-back: start held high in the DONE cycle with 77/8 → accepted; next done gives 9, 5, with no IDLE gap.
- ena=0 for 3 cycles mid-RUN → all registers hold; done delayed by exactly 3 cycles; result correct. rst_n pulsed mid-RUN → all outputs 0 asynchronously, no done, FSM in IDLE.
- DIVIDER_SIGNED_EN with signed_mode=1: -100/7 → 0xF2 (-14), 0xFE (-2). -128/-1 → 0x80, 0. 100/-7 → 0xF2, 0x02.

Source files
------------

// File: rtl/unsigned_divider_seq.sv
// Multi-cycle restoring divider: one quotient bit per enabled clock, start/busy/done handshake.
// Latency WIDTH+1 enabled edges (1 for divide-by-zero); ena=0 freezes all state; optional DIVIDER_SIGNED_EN.
module unsigned_divider_seq #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
`ifdef DIVIDER_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rmd_q, rmd_d;
    logic               dbz_q, dbz_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;

    logic [WIDTH:0]     rem_sh, rem_nx;
    logic [WIDTH-1:0]   q_nx, a_mag, b_mag, rem_lo;
    logic               ge, sgn_a, sgn_b;
    logic               unused_rem_msb;

    // The remainder never exceeds the divisor after an iteration, so its MSB is always 0 before the shift.
    assign unused_rem_msb = rem_q[WIDTH];

    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        sgn_a = signed_mode & dividend[WIDTH-1];
        sgn_b = signed_mode & divisor[WIDTH-1];
`else
        sgn_a = 1'b0;
        sgn_b = 1'b0;
`endif
        a_mag = sgn_a ? -dividend : dividend;
        b_mag = sgn_b ? -divisor : divisor;

        rem_sh = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, dvs_q};
        rem_nx = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        q_nx   = {q_q[WIDTH-2:0], ge};
        rem_lo = rem_nx[WIDTH-1:0];

        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        q_d       = q_q;
        dvs_d     = dvs_q;
        busy_d    = busy_q;
        done_d    = done_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dbz_d     = dbz_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        if (ena) begin
            case (state_q)
                RUN: begin
                    rem_d = rem_nx;
                    q_d   = q_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        quo_d   = neg_quo_q ? -q_nx : q_nx;
                        rmd_d   = neg_rem_q ? -rem_lo : rem_lo;
                    end
                end
                default: begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            quo_d   = '1;
                            rmd_d   = dividend;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d   = RUN;
                            busy_d    = 1'b1;
                            q_d       = a_mag;
                            dvs_d     = b_mag;
                            rem_d     = '0;
                            cnt_d     = '0;
                            dbz_d     = 1'b0;
                            neg_quo_d = sgn_a ^ sgn_b;
                            neg_rem_d = sgn_a;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dbz_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            dvs_q     <= dvs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dbz_q     <= dbz_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_unsigned_divider_seq.sv
// Directed self-checking bench for unsigned_divider_seq at WIDTH=8 (signed cases when DIVIDER_SIGNED_EN is defined).
module tb_unsigned_divider_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;
`ifdef DIVIDER_SIGNED_EN
    logic       signed_mode = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unsigned_divider_seq #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .start(start),
`ifdef DIVIDER_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    // Called at a negedge. Accepts one op, then counts edges until done is seen (bounded).
    // stall_at: edge after which ena drops for 3 cycles; poke_at: edge after which start is re-raised for 2 cycles.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall_at,
                          input int poke_at, output int edges, output int bcnt);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        edges = 1;
        bcnt = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && edges < 40) begin
            if (busy) bcnt++;
            if (edges == stall_at) ena = 1'b0;
            if (edges == stall_at + 3) ena = 1'b1;
            if (edges == poke_at) begin
                start = 1'b1;
                dividend = 8'd100;
                divisor = 8'd9;
            end
            if (edges == poke_at + 2) start = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input int edges, input int exp_edges,
                                input logic [7:0] eq, input logic [7:0] er, input logic ez);
        checks++;
        if (edges !== exp_edges) begin
            failures++;
            $display("FAIL %s latency: got %0d edges, want %0d", name, edges, exp_edges);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
            failures++;
            $display("FAIL %s result: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                     name, quotient, remainder, div_by_zero, eq, er, ez);
        end
    endtask

    task automatic check_pulse(input string name);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done pulse: done=%b one cycle later, want 0", name, done);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            failures++;
            $display("FAIL reset values: got busy=%b done=%b q=%h r=%h z=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int e, b;
        run_op(8'd200, 8'd7, 0, 0, e, b);
        check_result("200/7", e, 9, 8'd28, 8'd4, 1'b0);
        checks++;
        if (b !== 8) begin
            failures++;
            $display("FAIL 200/7 busy cycles: got %0d, want 8", b);
        end
        check_pulse("200/7");
        run_op(8'd255, 8'd1, 0, 0, e, b);
        check_result("255/1", e, 9, 8'd255, 8'd0, 1'b0);
        check_pulse("255/1");
    endtask

    task automatic test_div_zero();
        int e, b;
        run_op(8'd5, 8'd0, 0, 0, e, b);
        check_result("5/0", e, 1, 8'hFF, 8'd5, 1'b1);
        checks++;
        if (b !== 0) begin
            failures++;
            $display("FAIL 5/0 busy: got %0d busy cycles, want 0", b);
        end
        check_pulse("5/0");
        run_op(8'd9, 8'd3, 0, 0, e, b);
        check_result("9/3 after zero", e, 9, 8'd3, 8'd0, 1'b0);
        check_pulse("9/3");
    endtask

    task automatic test_start_in_run();
        int e, b;
        run_op(8'd3, 8'd10, 0, 3, e, b);
        check_result("3/10 with start in RUN", e, 9, 8'd0, 8'd3, 1'b0);
        check_pulse("3/10");
    endtask

    task automatic test_back_to_back();
        int e, b;
        run_op(8'd50, 8'd6, 0, 0, e, b);
        check_result("50/6", e, 9, 8'd8, 8'd2, 1'b0);
        run_op(8'd77, 8'd8, 0, 0, e, b);
        check_result("77/8 back-to-back", e, 9, 8'd9, 8'd5, 1'b0);
        check_pulse("77/8");
    endtask

    task automatic test_ena_stall();
        int e, b;
        run_op(8'd120, 8'd11, 4, 0, e, b);
        check_result("120/11 with ena stall", e, 12, 8'd10, 8'd10, 1'b0);
        checks++;
        if (b !== 11) begin
            failures++;
            $display("FAIL stall busy hold: got %0d busy cycles, want 11", b);
        end
        check_pulse("120/11");
    endtask

    task automatic test_reset_mid_run();
        int seen_done, seen_busy;
        start = 1'b1;
        dividend = 8'd200;
        divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            failures++;
            $display("FAIL async reset mid-run: got busy=%b done=%b q=%h r=%h z=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        seen_busy = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        checks++;
        if (seen_done + seen_busy !== 0) begin
            failures++;
            $display("FAIL post-reset idle: got done %0d, busy %0d cycles, want 0 and 0",
                     seen_done, seen_busy);
        end
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        int e, b;
        signed_mode = 1'b1;
        run_op(8'h9C, 8'd7, 0, 0, e, b);
        check_result("-100/7", e, 9, 8'hF2, 8'hFE, 1'b0);
        check_pulse("-100/7");
        run_op(8'h80, 8'hFF, 0, 0, e, b);
        check_result("-128/-1", e, 9, 8'h80, 8'h00, 1'b0);
        check_pulse("-128/-1");
        run_op(8'h64, 8'hF9, 0, 0, e, b);
        check_result("100/-7", e, 9, 8'hF2, 8'h02, 1'b0);
        check_pulse("100/-7");
        signed_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_start_in_run();
        test_back_to_back();
        test_ena_stall();
        test_reset_mid_run();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
